// File: rtl/wbsfifo_if.sv
// wbsfifo_if: bus bundle for the bridge FIFO.
//   master modport: the producer/consumer side. It drives the write/read strobes,
//                   the write data and the error clear, and observes the status.
//   slave modport:  the FIFO side.
//   Inputs to FIFO:    i_wr, i_data[BW], i_rd, i_clr_err
//   Outputs from FIFO: o_data[BW], o_rvalid, o_empty_n, o_full, o_fill[LGFLEN+1],
//                      o_afull, o_aempty, o_ovfl, o_unfl
interface wbsfifo_if #(
    parameter int unsigned BW     = 36,
    parameter int unsigned LGFLEN = 10
);
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              i_rd;
    logic              i_clr_err;
    logic [BW-1:0]     o_data;
    logic              o_rvalid;
    logic              o_empty_n;
    logic              o_full;
    logic [LGFLEN:0]   o_fill;
    logic              o_afull;
    logic              o_aempty;
    logic              o_ovfl;
    logic              o_unfl;

    modport master (
        output i_wr, i_data, i_rd, i_clr_err,
        input  o_data, o_rvalid, o_empty_n, o_full, o_fill,
               o_afull, o_aempty, o_ovfl, o_unfl
    );

    modport slave (
        input  i_wr, i_data, i_rd, i_clr_err,
        output o_data, o_rvalid, o_empty_n, o_full, o_fill,
               o_afull, o_aempty, o_ovfl, o_unfl
    );
endinterface

// File: rtl/wbsfifo_mem.sv
// wbsfifo_mem: simple dual-port RAM, BW x 2^LGFLEN, for the FIFO storage.
//   clk          clock
//   rst          synchronous reset; clears the read register only
//   we/waddr/wdata  synchronous write port
//   re/raddr     read enable and address
//   rdata        registered read data; a read of the address being written
//                returns the old contents
module wbsfifo_mem #(
    parameter int unsigned BW     = 36,
    parameter int unsigned LGFLEN = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [LGFLEN-1:0] waddr,
    input  logic [BW-1:0]     wdata,
    input  logic              re,
    input  logic [LGFLEN-1:0] raddr,
    output logic [BW-1:0]     rdata
);
    localparam int unsigned FLEN = 1 << LGFLEN;

    logic [BW-1:0] mem [FLEN];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/wbsfifo.sv
// wbsfifo: parametrised synchronous FIFO for the wishbone/JTAG bridge datapath.
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   bus      wbsfifo_if.slave: write/read strobes, data, status and sticky errors
// Parameters: BW data width, LGFLEN log2 depth, OPT_FWFT first-word-fall-through
// (1) or registered read (0), AFULL_LVL / AEMPTY_LVL threshold levels.
module wbsfifo #(
    parameter int unsigned BW         = 36,
    parameter int unsigned LGFLEN     = 10,
    parameter bit          OPT_FWFT   = 1'b1,
    parameter int unsigned AFULL_LVL  = (1 << LGFLEN) - 4,
    parameter int unsigned AEMPTY_LVL = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    wbsfifo_if.slave bus
);
    localparam int unsigned FLEN = 1 << LGFLEN;
    localparam int unsigned PW   = LGFLEN + 1;

    logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
    logic [PW-1:0]     fill, next_fill;
    logic              wr_acc, rd_acc;
    logic              bypass, bypass_q;
    logic [BW-1:0]     byp_data, mem_rdata;
    logic              mem_we, mem_re;
    logic [LGFLEN-1:0] mem_raddr;
    logic              full, empty_n, afull, aempty;
    logic              ovfl, unfl, rvalid;

    always_comb begin
        wr_acc     = bus.i_wr && (!full || bus.i_rd);
        rd_acc     = bus.i_rd && empty_n;
        next_fill  = fill + PW'(wr_acc) - PW'(rd_acc);
        rd_ptr_inc = rd_ptr + PW'(1);
        mem_we     = wr_acc && !i_rst;
        // The RAM cannot return a word written on the same edge, so in FWFT mode
        // a write that lands on the next head slot goes straight to o_data.
        bypass     = OPT_FWFT && wr_acc && (!empty_n || (rd_acc && fill == PW'(1)));
        // FWFT keeps the RAM read register tracking the (next) head every cycle;
        // registered mode only reads on an accepted read so o_data holds.
        mem_re     = OPT_FWFT ? 1'b1 : rd_acc;
        mem_raddr  = (OPT_FWFT && rd_acc) ? rd_ptr_inc[LGFLEN-1:0] : rd_ptr[LGFLEN-1:0];
    end

    wbsfifo_mem #(
        .BW     (BW),
        .LGFLEN (LGFLEN)
    ) u_mem (
        .clk   (i_clk),
        .rst   (i_rst),
        .we    (mem_we),
        .waddr (wr_ptr[LGFLEN-1:0]),
        .wdata (bus.i_data),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            full     <= 1'b0;
            empty_n  <= 1'b0;
            afull    <= (AFULL_LVL == 0);
            aempty   <= 1'b1;
            bypass_q <= 1'b0;
            byp_data <= '0;
            rvalid   <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr_inc;
            fill     <= next_fill;
            full     <= (32'(next_fill) == FLEN);
            empty_n  <= (next_fill != '0);
            afull    <= (32'(next_fill) >= AFULL_LVL);
            aempty   <= (32'(next_fill) <= AEMPTY_LVL);
            bypass_q <= bypass;
            if (bypass)
                byp_data <= bus.i_data;
            rvalid   <= !OPT_FWFT && rd_acc;
        end
    end

    // Sticky errors: a new error outranks a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovfl <= 1'b0;
            unfl <= 1'b0;
        end else begin
            if (bus.i_wr && !wr_acc)
                ovfl <= 1'b1;
            else if (bus.i_clr_err)
                ovfl <= 1'b0;
            if (bus.i_rd && !rd_acc)
                unfl <= 1'b1;
            else if (bus.i_clr_err)
                unfl <= 1'b0;
        end
    end

    assign bus.o_data    = (OPT_FWFT && bypass_q) ? byp_data : mem_rdata;
    assign bus.o_rvalid  = rvalid;
    assign bus.o_empty_n = empty_n;
    assign bus.o_full    = full;
    assign bus.o_fill    = fill;
    assign bus.o_afull   = afull;
    assign bus.o_aempty  = aempty;
    assign bus.o_ovfl    = ovfl;
    assign bus.o_unfl    = unfl;
endmodule

// File: tb/tb_wbsfifo.sv
// tb_wbsfifo: directed bench for wbsfifo, one FWFT instance and one registered-read
// instance (BW=8, LGFLEN=3, AFULL_LVL=6, AEMPTY_LVL=2), sharing clock and reset.
module tb_wbsfifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wbsfifo_if #(.BW(8), .LGFLEN(3)) f ();
    wbsfifo_if #(.BW(8), .LGFLEN(3)) r ();

    wbsfifo #(
        .BW(8), .LGFLEN(3), .OPT_FWFT(1'b1), .AFULL_LVL(6), .AEMPTY_LVL(2)
    ) u_fwft (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (f.slave)
    );

    wbsfifo #(
        .BW(8), .LGFLEN(3), .OPT_FWFT(1'b0), .AFULL_LVL(6), .AEMPTY_LVL(2)
    ) u_reg (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (r.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f.i_wr = 1'b0; f.i_rd = 1'b0; f.i_clr_err = 1'b0; f.i_data = '0;
        r.i_wr = 1'b0; r.i_rd = 1'b0; r.i_clr_err = 1'b0; r.i_data = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (f.o_fill !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", f.o_fill); end
        checks++; if (f.o_empty_n !== 1'b0) begin failures++; $display("FAIL reset_empty_n got=%b exp=0", f.o_empty_n); end
        checks++; if (f.o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", f.o_full); end
        checks++; if (f.o_afull !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", f.o_afull); end
        checks++; if (f.o_aempty !== 1'b1) begin failures++; $display("FAIL reset_aempty got=%b exp=1", f.o_aempty); end
        checks++; if ({f.o_ovfl, f.o_unfl} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {f.o_ovfl, f.o_unfl}); end
        checks++; if (f.o_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", f.o_data); end
        checks++; if (r.o_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", r.o_rvalid); end
        checks++; if (r.o_data !== 8'h00) begin failures++; $display("FAIL reset_reg_data got=%h exp=00", r.o_data); end
    endtask

    task automatic test_fwft_basic();
        for (int i = 1; i <= 5; i++) begin
            f.i_wr = 1'b1; f.i_data = 8'(i);
            tick();
            checks++; if (f.o_data !== 8'h01) begin failures++; $display("FAIL wr_head got=%h exp=01 after %0d writes", f.o_data, i); end
            checks++; if (f.o_aempty !== (i <= 2)) begin failures++; $display("FAIL wr_aempty got=%b after %0d writes", f.o_aempty, i); end
        end
        f.i_wr = 1'b0;
        checks++; if (f.o_fill !== 4'd5) begin failures++; $display("FAIL fill5 got=%0d exp=5", f.o_fill); end
        checks++; if (f.o_afull !== 1'b0) begin failures++; $display("FAIL afull5 got=%b exp=0", f.o_afull); end
        checks++; if (f.o_rvalid !== 1'b0) begin failures++; $display("FAIL fwft_rvalid got=%b exp=0", f.o_rvalid); end
        for (int i = 1; i <= 5; i++) begin
            checks++; if (f.o_data !== 8'(i)) begin failures++; $display("FAIL rd_stream got=%h exp=%h", f.o_data, 8'(i)); end
            f.i_rd = 1'b1;
            tick();
        end
        f.i_rd = 1'b0;
        checks++; if (f.o_empty_n !== 1'b0) begin failures++; $display("FAIL drained_empty_n got=%b exp=0", f.o_empty_n); end
        checks++; if (f.o_aempty !== 1'b1) begin failures++; $display("FAIL drained_aempty got=%b exp=1", f.o_aempty); end
        checks++; if (f.o_fill !== 4'd0) begin failures++; $display("FAIL drained_fill got=%0d exp=0", f.o_fill); end
        checks++; if (f.o_unfl !== 1'b0) begin failures++; $display("FAIL drained_unfl got=%b exp=0", f.o_unfl); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [8];
        for (int i = 0; i < 8; i++) begin
            f.i_wr = 1'b1; f.i_data = 8'(8'h20 + i);
            tick();
            checks++; if (f.o_afull !== (i + 1 >= 6)) begin failures++; $display("FAIL fill_afull got=%b at fill %0d", f.o_afull, i + 1); end
        end
        checks++; if (f.o_full !== 1'b1) begin failures++; $display("FAIL full8 got=%b exp=1", f.o_full); end
        checks++; if (f.o_fill !== 4'd8) begin failures++; $display("FAIL fill8 got=%0d exp=8", f.o_fill); end
        f.i_data = 8'hAA;
        tick();
        f.i_wr = 1'b0;
        checks++; if (f.o_ovfl !== 1'b1) begin failures++; $display("FAIL ovfl_set got=%b exp=1", f.o_ovfl); end
        checks++; if (f.o_fill !== 4'd8) begin failures++; $display("FAIL ovfl_fill got=%0d exp=8", f.o_fill); end
        checks++; if (f.o_data !== 8'h20) begin failures++; $display("FAIL ovfl_head got=%h exp=20", f.o_data); end
        f.i_clr_err = 1'b1;
        tick();
        f.i_clr_err = 1'b0;
        checks++; if (f.o_ovfl !== 1'b0) begin failures++; $display("FAIL ovfl_clr got=%b exp=0", f.o_ovfl); end
        f.i_wr = 1'b1; f.i_rd = 1'b1; f.i_data = 8'hBB;
        tick();
        f.i_wr = 1'b0; f.i_rd = 1'b0;
        checks++; if (f.o_fill !== 4'd8) begin failures++; $display("FAIL rw_full_fill got=%0d exp=8", f.o_fill); end
        checks++; if (f.o_full !== 1'b1) begin failures++; $display("FAIL rw_full_full got=%b exp=1", f.o_full); end
        checks++; if (f.o_ovfl !== 1'b0) begin failures++; $display("FAIL rw_full_ovfl got=%b exp=0", f.o_ovfl); end
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'hBB};
        for (int i = 0; i < 8; i++) begin
            checks++; if (f.o_data !== exp_q[i]) begin failures++; $display("FAIL drain_order got=%h exp=%h", f.o_data, exp_q[i]); end
            f.i_rd = 1'b1;
            tick();
        end
        f.i_rd = 1'b0;
        checks++; if (f.o_empty_n !== 1'b0) begin failures++; $display("FAIL ovfl_drain_empty got=%b exp=0", f.o_empty_n); end
    endtask

    task automatic test_underflow();
        f.i_rd = 1'b1; f.i_wr = 1'b1; f.i_data = 8'h07;
        tick();
        f.i_rd = 1'b0; f.i_wr = 1'b0;
        checks++; if (f.o_unfl !== 1'b1) begin failures++; $display("FAIL unfl_set got=%b exp=1", f.o_unfl); end
        checks++; if (f.o_fill !== 4'd1) begin failures++; $display("FAIL unfl_fill got=%0d exp=1", f.o_fill); end
        checks++; if (f.o_data !== 8'h07) begin failures++; $display("FAIL unfl_bypass got=%h exp=07", f.o_data); end
        tick();
        checks++; if (f.o_data !== 8'h07) begin failures++; $display("FAIL unfl_hold got=%h exp=07", f.o_data); end
        // read-at-fill-1 with a write: new word falls through
        f.i_rd = 1'b1; f.i_wr = 1'b1; f.i_data = 8'h3C;
        tick();
        f.i_wr = 1'b0;
        checks++; if (f.o_data !== 8'h3C) begin failures++; $display("FAIL fill1_rw_data got=%h exp=3c", f.o_data); end
        checks++; if (f.o_fill !== 4'd1) begin failures++; $display("FAIL fill1_rw_fill got=%0d exp=1", f.o_fill); end
        tick();
        f.i_rd = 1'b0;
        f.i_clr_err = 1'b1;
        tick();
        checks++; if (f.o_unfl !== 1'b0) begin failures++; $display("FAIL unfl_clr got=%b exp=0", f.o_unfl); end
        // set beats a coincident clear
        f.i_rd = 1'b1;
        tick();
        f.i_rd = 1'b0;
        checks++; if (f.o_unfl !== 1'b1) begin failures++; $display("FAIL unfl_set_wins got=%b exp=1", f.o_unfl); end
        tick();
        f.i_clr_err = 1'b0;
        checks++; if ({f.o_ovfl, f.o_unfl} !== 2'b00) begin failures++; $display("FAIL err_clr_both got=%b exp=00", {f.o_ovfl, f.o_unfl}); end
    endtask

    task automatic test_registered();
        r.i_wr = 1'b1; r.i_data = 8'h10;
        tick();
        r.i_data = 8'h11;
        tick();
        r.i_wr = 1'b0;
        checks++; if (r.o_fill !== 4'd2) begin failures++; $display("FAIL reg_fill got=%0d exp=2", r.o_fill); end
        checks++; if (r.o_rvalid !== 1'b0) begin failures++; $display("FAIL reg_rvalid_idle got=%b exp=0", r.o_rvalid); end
        checks++; if (r.o_data !== 8'h00) begin failures++; $display("FAIL reg_data_idle got=%h exp=00", r.o_data); end
        r.i_rd = 1'b1;
        tick();
        checks++; if ({r.o_rvalid, r.o_data} !== {1'b1, 8'h10}) begin failures++; $display("FAIL reg_rd1 got=%b/%h exp=1/10", r.o_rvalid, r.o_data); end
        tick();
        r.i_rd = 1'b0;
        checks++; if ({r.o_rvalid, r.o_data} !== {1'b1, 8'h11}) begin failures++; $display("FAIL reg_rd2 got=%b/%h exp=1/11", r.o_rvalid, r.o_data); end
        checks++; if (r.o_empty_n !== 1'b0) begin failures++; $display("FAIL reg_empty got=%b exp=0", r.o_empty_n); end
        tick();
        checks++; if ({r.o_rvalid, r.o_data} !== {1'b0, 8'h11}) begin failures++; $display("FAIL reg_hold got=%b/%h exp=0/11", r.o_rvalid, r.o_data); end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] d;
        bit wr, rd, wa, ra, m_ovfl, m_unfl;
        m_ovfl = 1'b0;
        m_unfl = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (c < 40) begin
                wr = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 3) == 0);
            end else begin
                wr = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end
            d  = 8'($urandom);
            ra = rd && (q.size() > 0);
            wa = wr && (q.size() < 8 || rd);
            if (wr && !wa) m_ovfl = 1'b1;
            if (rd && !ra) m_unfl = 1'b1;
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(d);
            f.i_wr = wr; f.i_rd = rd; f.i_data = d;
            tick();
            checks++; if (f.o_fill !== 4'(q.size())) begin failures++; $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", c, f.o_fill, q.size()); end
            checks++; if ({f.o_full, f.o_empty_n, f.o_afull, f.o_aempty} !== {q.size() == 8, q.size() != 0, q.size() >= 6, q.size() <= 2})
                begin failures++; $display("FAIL rnd_flags cyc=%0d got=%b fill=%0d", c, {f.o_full, f.o_empty_n, f.o_afull, f.o_aempty}, q.size()); end
            checks++; if ({f.o_ovfl, f.o_unfl} !== {m_ovfl, m_unfl}) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, {f.o_ovfl, f.o_unfl}, {m_ovfl, m_unfl}); end
            if (q.size() > 0) begin
                checks++; if (f.o_data !== q[0]) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, f.o_data, q[0]); end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        f.i_rd = 1'b1;
        tick();
        f.i_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f.i_wr = 1'b1; f.i_data = 8'(8'h40 + i);
            r.i_wr = 1'b1; r.i_data = 8'(8'h50 + i);
            tick();
        end
        f.i_rd = 1'b1; f.i_data = 8'h55; r.i_rd = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        checks++; if (f.o_fill !== 4'd0) begin failures++; $display("FAIL rst_mid_fill got=%0d exp=0", f.o_fill); end
        checks++; if ({f.o_empty_n, f.o_full, f.o_afull, f.o_aempty} !== 4'b0001) begin failures++; $display("FAIL rst_mid_flags got=%b exp=0001", {f.o_empty_n, f.o_full, f.o_afull, f.o_aempty}); end
        checks++; if ({f.o_ovfl, f.o_unfl} !== 2'b00) begin failures++; $display("FAIL rst_mid_err got=%b exp=00", {f.o_ovfl, f.o_unfl}); end
        checks++; if (f.o_data !== 8'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", f.o_data); end
        checks++; if ({r.o_fill, r.o_rvalid, r.o_data} !== 13'd0) begin failures++; $display("FAIL rst_mid_reg got=%0d/%b/%h exp=0/0/00", r.o_fill, r.o_rvalid, r.o_data); end
        f.i_wr = 1'b1; f.i_data = 8'h66;
        tick();
        f.i_wr = 1'b0;
        checks++; if ({f.o_fill, f.o_data} !== {4'd1, 8'h66}) begin failures++; $display("FAIL rst_after_wr got=%0d/%h exp=1/66", f.o_fill, f.o_data); end
        f.i_rd = 1'b1;
        tick();
        f.i_rd = 1'b0;
        checks++; if ({f.o_fill, f.o_empty_n} !== {4'd0, 1'b0}) begin failures++; $display("FAIL rst_after_rd got=%0d/%b exp=0/0", f.o_fill, f.o_empty_n); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fwft_basic();
        test_overflow();
        test_underflow();
        test_registered();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wbsfifo.md
# wbsfifo

Parametrised synchronous FIFO for the wishbone/JTAG bridge datapath. It generalises the bridge's codeword FIFO with:
- exact fill count, full flag and programmable almost-full/almost-empty thresholds;
- a first-word-fall-through (FWFT) or registered-read mode selected by parameter;
- separate sticky overflow/underflow flags.

It sits between the bridge's command decoder and the wishbone master, and equally on the return path.

## Interface
- BW, 36, data width in bits (>=1)
- LGFLEN, 10, log2 of depth; capacity FLEN = 2^LGFLEN entries (all usable)
- OPT_FWFT, 1, 1 = head word presented on o_data whenever o_empty_n; 0 = registered read, data one cycle after i_rd
- AFULL_LVL, FLEN-4, o_afull asserts when fill >= AFULL_LVL
- AEMPTY_LVL, 4, o_aempty asserts when fill <= AEMPTY_LVL
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_wr  in  1  write strobe
- i_data  in  BW  write data
- i_rd  in  1  read strobe
- i_clr_err  in  1  clears o_ovfl/o_unfl
- o_data  out  BW  read data, registered
- o_rvalid  out  1  OPT_FWFT=0 only: o_data valid this cycle; tied 0 when OPT_FWFT=1
- o_empty_n  out  1  FIFO holds at least one word
- o_full  out  1  fill == FLEN
- o_fill  out  LGFLEN+1  current entry count, 0..FLEN
- o_afull, o_aempty  out  1  threshold flags
- o_ovfl, o_unfl  out  1  sticky error flags

## Operation
- Pointers are LGFLEN+1 bits wide. Wrap is modulo 2^(LGFLEN+1). Full = MSBs differ and the low bits are equal.
- Accepted write: `i_wr && (!o_full || i_rd)`. Writes i_data at the write pointer; the write pointer increments.
- Accepted read: `i_rd && o_empty_n`. The read pointer increments.
- A read on an empty FIFO is rejected even with a simultaneous write; that write is still accepted.
- Rejected write: sets o_ovfl the next cycle; FIFO contents are unchanged.
- Rejected read: sets o_unfl the next cycle.
- Sticky flags hold until i_clr_err or i_rst. If a set and i_clr_err occur together, set wins.
- Fill update: `o_fill <= o_fill + wr_acc - rd_acc`.
- Derived flags are registered alongside o_fill: o_full, o_empty_n, o_afull, o_aempty. All are exact on the same cycle as o_fill; none is a lagging approximation.
- FWFT mode: o_data always equals the oldest stored word while o_empty_n=1. Bypass cases:
  - write into an empty FIFO;
  - read with fill==1 plus a simultaneous write.
  In both cases i_data goes directly to o_data.
- FWFT mode, otherwise: o_data loads mem[rd_ptr+1] on an accepted read, or mem[rd_ptr] while idle.
- Registered mode: an accepted read loads o_data with the head word and pulses o_rvalid for 1 cycle. o_data holds otherwise.

## Timing
- Reset values:
  - pointers 0, o_fill 0, o_empty_n 0, o_full 0;
  - o_afull = (0 >= AFULL_LVL), o_aempty 1;
  - o_ovfl 0, o_unfl 0, o_rvalid 0, o_data 0.
- Write-to-visible latency: 1 cycle. An accepted write at edge N gives o_empty_n=1 after N; in FWFT mode o_data is valid at that point too.
- Registered-mode read latency: 1 cycle, from i_rd at edge N to o_rvalid/o_data after N.
- Back-to-back reads every cycle stream one word per cycle in both modes, with no bubbles.
- Simultaneous read and write at full: both accepted; fill stays FLEN; no o_ovfl.
- Simultaneous read and write at fill 1 (FWFT): o_data becomes i_data next cycle; fill stays 1.
- i_rst mid-operation empties the FIFO next cycle. Memory contents are don't-care. Any op presented in the reset cycle is ignored.
- Pointer wrap past 2^LGFLEN entries must be seamless: ordering preserved, fill correct.

## Structure
- No shared package. All constants derive locally from parameters.
- One natural sub-module, `wbsfifo_mem`:
  - simple dual-port RAM, BW x FLEN;
  - synchronous write;
  - registered read with address input.
  - Keeps the memory inferable as block RAM.
- Top level holds pointers, fill/flag logic, bypass mux and error flags.
- Target 150-300 lines total.

## Test plan
- Reset, then write 5 words 0x1..0x5 (FWFT, LGFLEN=3) -> o_fill 5, o_data=0x1; 5 reads -> 0x1..0x5 in order, then o_empty_n=0, o_aempty=1.
- Fill 8 of 8, then write 0xAA alone -> o_full=1, o_ovfl=1, contents unchanged; then simultaneous read and write of 0xBB -> fill stays 8, 0xBB emerges last.
- Read on empty with a simultaneous write of 0x7 -> o_unfl=1, o_fill=1, o_data=0x7; i_clr_err -> both sticky flags clear.
- Registered mode: write 0x10, 0x11; read two consecutive cycles -> o_rvalid high 2 cycles with 0x10 then 0x11, each 1 cycle after its i_rd.
- Continuous random read/write for 10*FLEN cycles against a scoreboard model -> data order, o_fill and all flags match every cycle across pointer wraps.
- Assert i_rst with the FIFO half full while reads and writes are active -> next cycle all outputs equal their reset values; a following write/read round-trips correctly.
